// File: rtl/seq_player_pkg.sv
// Shared types and constants for the sequence player.
package seq_player_pkg;

  // Playback controller states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_TICK = 2'd2,
    READ      = 2'd3
  } seq_state_t;

  // Two LSBs of a pattern word that mark the end of a sequence.
  localparam logic [1:0] END_CODE = 2'b11;

  function automatic logic is_end_word(input logic [1:0] lsbs);
    return lsbs == END_CODE;
  endfunction

endpackage

// File: rtl/seq_sel_counter.sv
// Pushbutton edge detection and wrapping up/down sequence-number counter.
module seq_sel_counter #(
  parameter int unsigned SEQ_W   = 6,
  parameter int unsigned NUM_SEQ = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             dn,
  input  logic             hold,
  output logic [SEQ_W-1:0] seq_num
);

  localparam logic [SEQ_W-1:0] LAST = SEQ_W'(NUM_SEQ - 1);

  logic             up_q, dn_q;
  logic             up_edge, dn_edge;
  logic [SEQ_W-1:0] seq_d;

  // Rising edges against the registered previous level; opposing edges cancel.
  always_comb begin
    up_edge = up & ~up_q;
    dn_edge = dn & ~dn_q;
    seq_d   = seq_num;
    if (!hold) begin
      if (up_edge && !dn_edge) begin
        seq_d = (seq_num == LAST) ? '0 : seq_num + 1'b1;
      end else if (dn_edge && !up_edge) begin
        seq_d = (seq_num == '0) ? LAST : seq_num - 1'b1;
      end
    end
  end

  // Edge-detect history and the counter itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      seq_num <= '0;
    end else begin
      up_q    <= up;
      dn_q    <= dn;
      seq_num <= seq_d;
    end
  end

endmodule

// File: rtl/seq_player.sv
// Sequence player: tag table of start addresses, pushbutton sequence select and a
// step_tick-paced playback FSM reading one pattern-ROM word per tick until the end code.
// Optional build macro SEQ_PLAYER_RUNAWAY_EN adds a per-pass word limit (MAX_LEN) that
// sets the sticky err flag; without it err is tied low.
module seq_player
  import seq_player_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEQ_W   = 6,
  parameter int unsigned NUM_SEQ = 64,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              pb_seq_up,
  input  logic              pb_seq_dn,
  input  logic              play,
  input  logic              stop,
  input  logic              mode_loop,
  input  logic              step_tick,
  input  logic              tag_we,
  input  logic [SEQ_W-1:0]  tag_seq,
  input  logic [ADDR_W-1:0] tag_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [SEQ_W-1:0]  seq_num,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_t        state_q, state_d;
  logic              play_q;
  logic              play_rise;
  logic              end_word;
  logic              runaway;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] tag_table [NUM_SEQ];

  assign play_rise = play & ~play_q;
  assign end_word  = is_end_word(rom_data[1:0]);
  assign busy      = (state_q != IDLE);

  seq_sel_counter #(
    .SEQ_W   (SEQ_W),
    .NUM_SEQ (NUM_SEQ)
  ) u_sel (
    .clk     (CLK_50),
    .rst_n   (reset),
    .up      (pb_seq_up),
    .dn      (pb_seq_dn),
    .hold    (busy),
    .seq_num (seq_num)
  );

`ifdef SEQ_PLAYER_RUNAWAY_EN
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  logic [CNT_W-1:0] wcnt_q;

  // This read would be the MAX_LEN-th word of the pass with no end code in sight.
  assign runaway = (state_q == READ) && !end_word && (wcnt_q == CNT_W'(MAX_LEN - 1));

  // Words-per-pass counter and sticky runaway flag; stop pre-empts both.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      wcnt_q <= '0;
      err    <= 1'b0;
    end else if (!stop) begin
      if (state_q == ARM) begin
        wcnt_q <= '0;
      end else if (state_q == READ) begin
        wcnt_q <= end_word ? '0 : wcnt_q + 1'b1;
      end
      if (runaway) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_max_len;

  assign runaway        = 1'b0;
  assign err            = 1'b0;
  assign unused_max_len = (MAX_LEN == 0);
`endif

  // Next-state logic; stop wins over every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (play_rise) state_d = ARM;
      ARM:       state_d = WAIT_TICK;
      WAIT_TICK: if (step_tick) state_d = READ;
      READ: begin
        if (end_word) begin
          state_d = mode_loop ? WAIT_TICK : IDLE;
        end else if (runaway) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      default:   state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
    end
  end

  // Tag table writes; out-of-range indices are silently dropped.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_SEQ); i++) begin
        tag_table[i] <= '0;
      end
    end else if (tag_we && (32'(tag_seq) < NUM_SEQ)) begin
      tag_table[tag_seq] <= tag_addr;
    end
  end

  // FSM state, address pointer and output registers.
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      play_q     <= 1'b0;
      ptr_q      <= '0;
      start_q    <= '0;
      rom_addr   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      play_q     <= play;
      word_valid <= 1'b0;
      done       <= 1'b0;
      // On stop, rom_addr and word_out simply hold.
      if (!stop) begin
        unique case (state_q)
          ARM: begin
            ptr_q    <= tag_table[seq_num];
            start_q  <= tag_table[seq_num];
            rom_addr <= tag_table[seq_num];
          end
          READ: begin
            word_out   <= rom_data;
            word_valid <= 1'b1;
            if (end_word && mode_loop) begin
              ptr_q    <= start_q;
              rom_addr <= start_q;
            end else if (end_word) begin
              done <= 1'b1;
            end else begin
              ptr_q    <= ptr_q + 1'b1;
              rom_addr <= ptr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with a word scoreboard checked against a synchronous ROM model.
module tb_seq_player;

  logic        clk;
  logic        reset;
  logic        pb_seq_up, pb_seq_dn, play, stop, mode_loop, step_tick, tag_we;
  logic [5:0]  tag_seq;
  logic [9:0]  tag_addr;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [5:0]  seq_num;
  logic [31:0] word_out;
  logic        word_valid, busy, done, err;

  logic [31:0] rom [1024];

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   done_cnt   = 0;
  int   valid_cnt  = 0;
  int   snap;

  seq_player #(
    .ADDR_W  (10),
    .DATA_W  (32),
    .SEQ_W   (6),
    .NUM_SEQ (64),
    .MAX_LEN (4)
  ) dut (
    .CLK_50     (clk),
    .reset      (reset),
    .pb_seq_up  (pb_seq_up),
    .pb_seq_dn  (pb_seq_dn),
    .play       (play),
    .stop       (stop),
    .mode_loop  (mode_loop),
    .step_tick  (step_tick),
    .tag_we     (tag_we),
    .tag_seq    (tag_seq),
    .tag_addr   (tag_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .seq_num    (seq_num),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every word_valid must match the oldest pending word and its due cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (word_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_word_valid", 64'(word_out), 64'hdead_dead_dead_dead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word", 64'(word_out), 64'(e.word));
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_btn(input logic u, input logic d);
    pb_seq_up = u;
    pb_seq_dn = d;
    step(1);
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    step(1);
  endtask

  task automatic write_tag(input logic [5:0] s, input logic [9:0] a);
    tag_we   = 1'b1;
    tag_seq  = s;
    tag_addr = a;
    step(1);
    tag_we = 1'b0;
  endtask

  task automatic start_play();
    play = 1'b1;
    step(1);
    play = 1'b0;
    step(3);
  endtask

  // Expect a ROM read at addr; returns in the cycle word_valid is high.
  task automatic tick(input logic [9:0] addr);
    exp_t e;
    check("rom_addr_before_tick", 64'(rom_addr), 64'(addr));
    e.word = rom[addr];
    e.cyc  = cyc + 2;
    sb.push_back(e);
    step_tick = 1'b1;
    step(1);
    step_tick = 1'b0;
    step(1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | (i << 2);
    rom[10'h041] = 32'h0000_4101;
    rom[10'h042] = 32'h0000_4203;
    reset = 1'b0; pb_seq_up = 1'b0; pb_seq_dn = 1'b0; play = 1'b0; stop = 1'b0;
    mode_loop = 1'b0; step_tick = 1'b0; tag_we = 1'b0; tag_seq = '0; tag_addr = '0;
    step(3);
    check("rst_rom_addr", 64'(rom_addr), 0);
    check("rst_seq_num", 64'(seq_num), 0);
    check("rst_word_out", 64'(word_out), 0);
    check("rst_word_valid", 64'(word_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    reset = 1'b1;
    step(2);

    // Sequence select.
    repeat (3) pulse_btn(1'b1, 1'b0);
    check("sel_up3", 64'(seq_num), 3);
    repeat (3) pulse_btn(1'b0, 1'b1);
    check("sel_dn_to0", 64'(seq_num), 0);
    pulse_btn(1'b0, 1'b1);
    check("sel_dn_wrap", 64'(seq_num), 63);
    pulse_btn(1'b1, 1'b1);
    check("sel_both", 64'(seq_num), 63);
    pulse_btn(1'b1, 1'b0);
    check("sel_up_wrap", 64'(seq_num), 0);
    repeat (2) pulse_btn(1'b1, 1'b0);
    check("sel_two", 64'(seq_num), 2);

    write_tag(6'd2, 10'h040);
    write_tag(6'd3, 10'h3FF);
    write_tag(6'd4, 10'h100);
    step(1);

    // One-shot playback.
    start_play();
    check("oneshot_busy", 64'(busy), 1);
    tick(10'h040);
    tick(10'h041);
    tick(10'h042);
    check("oneshot_done", 64'(done), 1);
    check("oneshot_idle", 64'(busy), 0);
    step(1);
    check("done_one_cycle", 64'(done), 0);
    check("done_cnt_oneshot", 64'(done_cnt), 1);
    check("oneshot_word_out", 64'(word_out), 64'(rom[10'h042]));

    // Loop playback, then stop.
    mode_loop = 1'b1;
    start_play();
    tick(10'h040);
    tick(10'h041);
    tick(10'h042);
    tick(10'h040);
    tick(10'h041);
    check("loop_busy", 64'(busy), 1);
    check("loop_no_done", 64'(done_cnt), 1);
    pulse_stop();
    check("stop_idle", 64'(busy), 0);
    check("stop_addr_hold", 64'(rom_addr), 64'h042);
    check("stop_word_hold", 64'(word_out), 64'(rom[10'h041]));

    // stop beats a same-cycle play edge.
    play = 1'b1;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    play = 1'b0;
    check("stop_over_play", 64'(busy), 0);
    step(1);

    // Address wrap, select ignored while busy, stop mid-sequence.
    mode_loop = 1'b0;
    pulse_btn(1'b1, 1'b0);
    check("sel_three", 64'(seq_num), 3);
    start_play();
    tick(10'h3FF);
    check("addr_wrap", 64'(rom_addr), 0);
    tick(10'h000);
    pulse_btn(1'b1, 1'b0);
    check("sel_hold_busy", 64'(seq_num), 3);
    pulse_stop();
    check("stop_mid_idle", 64'(busy), 0);
    check("stop_mid_no_done", 64'(done_cnt), 1);
    check("stop_mid_addr", 64'(rom_addr), 1);
    check("stop_mid_word", 64'(word_out), 64'(rom[10'h000]));

`ifdef SEQ_PLAYER_RUNAWAY_EN
    // Runaway limit of 4 words.
    pulse_btn(1'b1, 1'b0);
    check("sel_four", 64'(seq_num), 4);
    start_play();
    tick(10'h100);
    tick(10'h101);
    tick(10'h102);
    check("runaway_not_yet", 64'(err), 0);
    tick(10'h103);
    check("runaway_err", 64'(err), 1);
    check("runaway_idle", 64'(busy), 0);
    check("runaway_no_done", 64'(done_cnt), 1);
    start_play();
    check("runaway_replay_busy", 64'(busy), 1);
    check("runaway_sticky", 64'(err), 1);
    pulse_stop();
`else
    check("err_tied_low", 64'(err), 0);
`endif

    // Asynchronous reset in READ.
    start_play();
    step_tick = 1'b1;
    step(1);
    step_tick = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_rom_addr", 64'(rom_addr), 0);
    check("arst_seq_num", 64'(seq_num), 0);
    check("arst_word_out", 64'(word_out), 0);
    check("arst_err", 64'(err), 0);
    check("arst_word_valid", 64'(word_valid), 0);
    step(2);
    reset = 1'b1;
    step(2);

    // Ticks in IDLE are dropped.
    snap = valid_cnt;
    step_tick = 1'b1;
    step(5);
    step_tick = 1'b0;
    step(4);
    check("idle_ticks_dropped", 64'(valid_cnt), 64'(snap));
    check("idle_ticks_busy", 64'(busy), 0);
    check("sb_drained", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
